// File: rtl/av2_fb_arbiter.sv
// ---------------------------------------------------------------------------
// av2_fb_arbiter
//   Round-robin burst arbiter sharing the frame buffer controller's single
//   write port and single read port between NREQ requesters. A grant covers a
//   whole burst (ended by req_last or cut off after MAX_BURST beats). Read
//   data returns one cycle after the accepted read beat and is steered to the
//   requester that issued it via rsp_valid.
//
//   Optional feature (compile-time macro): AV2_FBA_WRITE_PRIORITY_EN
//     defined   - at arbitration, requesters presenting a write beat win over
//                 requesters presenting a read beat; round-robin among writers.
//     undefined - pure round-robin, req_we ignored for arbitration.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     per-requester beat handshake
//   req_we/last/plane   per-requester beat type, end-of-burst, plane (2b/req)
//   req_addr/wdata      per-requester address and write data slices
//   rsp_valid/data      per-requester read valid, shared read data bus
//   fb_wr_*             frame buffer write port (en/addr/data)
//   fb_rd_*             frame buffer read port (en/addr/plane), fb_rd_data in
//   owner, busy         current grant holder, grant active
//   err_overrun         one-cycle pulse after a burst is cut at MAX_BURST
// ---------------------------------------------------------------------------
module av2_fb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int NREQ       = 3,
  parameter int MAX_BURST  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ-1:0]            req_last,
  input  logic [2*NREQ-1:0]          req_plane,
  input  logic [ADDR_WIDTH*NREQ-1:0] req_addr,
  input  logic [DATA_WIDTH*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       fb_wr_en,
  output logic [ADDR_WIDTH-1:0]      fb_wr_addr,
  output logic [DATA_WIDTH-1:0]      fb_wr_data,
  output logic                       fb_rd_en,
  output logic [ADDR_WIDTH-1:0]      fb_rd_addr,
  output logic [1:0]                 fb_rd_plane,
  input  logic [DATA_WIDTH-1:0]      fb_rd_data,
  output logic [$clog2(NREQ)-1:0]    owner,
  output logic                       busy,
  output logic                       err_overrun
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            err_q, err_d;

  // {found, index}: first set bit of cand scanning ptr, ptr+1, ... mod NREQ.
  // The candidates are rotated so that offset 0 corresponds to ptr; scanning
  // offsets from high to low lets the smallest offset win.
  function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] cand,
                                          input logic [OW-1:0]   ptr);
    logic [2*NREQ-1:0] rot;
    logic [OW:0]       sum;
    logic [OW:0]       res;
    rot = {cand, cand} >> ptr;
    sum = '0;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr} + (OW+1)'(i);
        if (sum >= (OW+1)'(NREQ)) sum = sum - (OW+1)'(NREQ);
        res = {1'b1, sum[OW-1:0]};
      end
    end
    return res;
  endfunction

  logic [OW:0] pick;
`ifdef AV2_FBA_WRITE_PRIORITY_EN
  logic [OW:0] pick_wr;
  logic [OW:0] pick_all;
  assign pick_wr  = rr_pick(req_valid & req_we, rr_ptr_q);
  assign pick_all = rr_pick(req_valid, rr_ptr_q);
  assign pick     = pick_wr[OW] ? pick_wr : pick_all;
`else
  assign pick     = rr_pick(req_valid, rr_ptr_q);
`endif

  // Owner's slice of the request bundle.
  logic                  own_valid, own_we, own_last;
  logic [1:0]            own_plane;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic [OW-1:0]         next_ptr;

  assign own_valid = req_valid[owner_q];
  assign own_we    = req_we[owner_q];
  assign own_last  = req_last[owner_q];
  assign own_plane = req_plane[2*int'(owner_q) +: 2];
  assign own_addr  = req_addr[ADDR_WIDTH*int'(owner_q) +: ADDR_WIDTH];
  assign own_wdata = req_wdata[DATA_WIDTH*int'(owner_q) +: DATA_WIDTH];
  assign next_ptr  = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    rsp_valid_d = '0;
    err_d       = 1'b0;
    req_ready   = '0;
    fb_wr_en    = 1'b0;
    fb_wr_addr  = '0;
    fb_wr_data  = '0;
    fb_rd_en    = 1'b0;
    fb_rd_addr  = '0;
    fb_rd_plane = '0;

    unique case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (pick[OW]) begin
          owner_d = pick[OW-1:0];
          state_d = BUSY;
        end
      end
      BUSY: begin
        req_ready[owner_q] = 1'b1;
        if (own_valid) begin
          if (own_we) begin
            fb_wr_en   = 1'b1;
            fb_wr_addr = own_addr;
            fb_wr_data = own_wdata;
          end else begin
            fb_rd_en             = 1'b1;
            fb_rd_addr           = own_addr;
            fb_rd_plane          = own_plane;
            rsp_valid_d[owner_q] = 1'b1;
          end
          beat_cnt_d = beat_cnt_q + 1'b1;
          // Burst ends on req_last or is cut once MAX_BURST beats are taken.
          if (own_last || beat_cnt_q == CW'(MAX_BURST - 1)) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = next_ptr;
            err_d      = !own_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register sees
  // the pre-edge values of the others. Clearing rsp_valid_q here is what drops
  // a read response still in flight when reset hits mid-burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      rsp_valid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  // Read data passes straight through; held at zero when nobody is owed data.
  assign rsp_data    = (|rsp_valid_q) ? fb_rd_data : '0;
  assign owner       = owner_q;
  assign busy        = (state_q == BUSY);
  assign err_overrun = err_q;

endmodule

// File: tb/tb_av2_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_av2_fb_arbiter
//   Self-checking bench for av2_fb_arbiter (NREQ=3, MAX_BURST=16). Per-
//   requester burst drivers feed the DUT; a burst-level reference model
//   predicts grants, port enables, read responses and overrun pulses each
//   cycle. A simple frame buffer with one-cycle read latency answers reads.
//   Build with +define+AV2_FBA_WRITE_PRIORITY_EN to exercise write priority.
// ---------------------------------------------------------------------------
module tb_av2_fb_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 128;
  localparam int NREQ = 3;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid, req_ready, req_we, req_last, rsp_valid;
  logic [2*NREQ-1:0]  req_plane;
  logic [AW*NREQ-1:0] req_addr;
  logic [DW*NREQ-1:0] req_wdata;
  logic [DW-1:0]      rsp_data, fb_wr_data;
  logic [DW-1:0]      fb_rd_data = '0;
  logic               fb_wr_en, fb_rd_en, busy, err_overrun;
  logic [AW-1:0]      fb_wr_addr, fb_rd_addr;
  logic [1:0]         fb_rd_plane;
  logic [1:0]         owner;

  av2_fb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NREQ), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_last(req_last),
    .req_plane(req_plane), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_plane(fb_rd_plane),
    .fb_rd_data(fb_rd_data),
    .owner(owner), .busy(busy), .err_overrun(err_overrun)
  );

  // Frame buffer contents are a fixed function of plane and address.
  function automatic logic [DW-1:0] mem_word(input logic [1:0] p, input logic [AW-1:0] a);
    return {a * 32'h9E37_79B9, ~a, 30'h0, p, a};
  endfunction

  always @(posedge clk) if (fb_rd_en) fb_rd_data <= mem_word(fb_rd_plane, fb_rd_addr);

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- burst drivers ----------------
  typedef struct {
    bit act;
    int len;       // beats in this burst
    int last_at;   // beat index carrying req_last (may be >= len: never)
    int beat;
    int mode;      // 0 read, 1 write, 2 random per beat
    int addr0;
    int plane;
    int gap_at;    // beat index before which valid drops for gap_len cycles
    int gap_len;
    int gap_cnt;
    int drop_pct;  // random per-cycle valid drop
    int reps;      // further identical bursts after this one
    bit cur_we;
  } drv_t;

  drv_t drv[NREQ];

  function automatic bit pick_we(input int mode);
    if (mode == 2) return bit'($urandom_range(1));
    return (mode == 1);
  endfunction

  task automatic start_burst(input int i, input int len, input int last_at, input int mode,
                             input int addr0, input int plane, input int gap_at,
                             input int gap_len, input int drop_pct, input int reps);
    drv[i].act = 1'b1;   drv[i].len = len;       drv[i].last_at = last_at;
    drv[i].beat = 0;     drv[i].mode = mode;     drv[i].addr0 = addr0;
    drv[i].plane = plane; drv[i].gap_at = gap_at; drv[i].gap_len = gap_len;
    drv[i].gap_cnt = 0;  drv[i].drop_pct = drop_pct; drv[i].reps = reps;
    drv[i].cur_we = pick_we(mode);
  endtask

  function automatic bit any_active();
    for (int i = 0; i < NREQ; i++) if (drv[i].act) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- reference model ----------------
  int          m_own;       // current grant holder, -1 when no grant
  int          m_ptr;       // round-robin start point
  int          m_cnt;       // beats taken in the current grant
  int          m_rsp_own;   // requester owed read data this cycle, -1 none
  logic [AW-1:0] m_rsp_addr;
  logic [1:0]  m_rsp_plane;
  bit          m_err;       // overrun pulse expected this cycle

  // observations used by the directed phases
  int  starts[$];
  bit  prev_busy;
  int  err_seen;
  int  rsp_cnt1;

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_cnt = 0; m_rsp_own = -1; m_err = 1'b0;
  endtask

  function automatic int pick_winner();
    int w, j;
    w = -1;
`ifdef AV2_FBA_WRITE_PRIORITY_EN
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (w < 0 && req_valid[j] && req_we[j]) w = j;
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (w < 0 && req_valid[j]) w = j;
    end
    return w;
  endfunction

  // One clock cycle: called at a falling edge, drives inputs, checks outputs,
  // advances model and drivers at the rising edge, returns at the next fall.
  task automatic step();
    bit stall, acc;
    int cur;
    logic [NREQ-1:0] exp_ready, exp_rsp;
    logic [AW-1:0]   a;
    for (int i = 0; i < NREQ; i++) begin
      stall = (drv[i].beat == drv[i].gap_at) && (drv[i].gap_cnt < drv[i].gap_len);
      if (int'($urandom_range(99)) < drv[i].drop_pct) stall = 1'b1;
      a = AW'(drv[i].addr0 + drv[i].beat);
      if (!drv[i].act) a = $urandom;
      req_valid[i] = drv[i].act && !stall;
      req_we[i]    = drv[i].act ? drv[i].cur_we : bit'($urandom_range(1));
      req_last[i]  = drv[i].act && (drv[i].beat == drv[i].last_at);
      req_plane[2*i +: 2] = 2'(drv[i].plane);
      req_addr[AW*i +: AW] = a;
      req_wdata[DW*i +: DW] = {~a, a, 32'(i), 32'(drv[i].beat)};
    end

    #1;
    cur = m_own;
    acc = 1'b0;
    exp_ready = '0;
    if (cur >= 0) begin
      exp_ready[cur] = 1'b1;
      acc = req_valid[cur];
    end
    exp_rsp = '0;
    if (m_rsp_own >= 0) exp_rsp[m_rsp_own] = 1'b1;

    check("req_ready", req_ready, exp_ready);
    check("ready_onehot", $onehot0(req_ready), 1'b1);
    check("busy", busy, cur >= 0);
    if (cur >= 0) check("owner", owner, cur);
    check("fb_wr_en", fb_wr_en, acc && req_we[cur]);
    check("fb_rd_en", fb_rd_en, acc && !req_we[cur]);
    if (acc && req_we[cur]) begin
      check("fb_wr_addr", fb_wr_addr, req_addr[AW*cur +: AW]);
      check("fb_wr_data", fb_wr_data, req_wdata[DW*cur +: DW]);
    end
    if (acc && !req_we[cur]) begin
      check("fb_rd_addr", fb_rd_addr, req_addr[AW*cur +: AW]);
      check("fb_rd_plane", fb_rd_plane, req_plane[2*cur +: 2]);
    end
    check("rsp_valid", rsp_valid, exp_rsp);
    if (m_rsp_own >= 0) check("rsp_data", rsp_data, mem_word(m_rsp_plane, m_rsp_addr));
    check("err_overrun", err_overrun, m_err);

    if (busy && !prev_busy) starts.push_back(int'(owner));
    prev_busy = busy;
    err_seen += int'(err_overrun);
    rsp_cnt1 += int'(rsp_valid[1]);

    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < NREQ; i++)
        if (drv[i].act && drv[i].beat == drv[i].gap_at && drv[i].gap_cnt < drv[i].gap_len)
          drv[i].gap_cnt++;
      m_rsp_own = -1;
      m_err     = 1'b0;
      if (cur < 0) begin
        m_own = pick_winner();
      end else if (acc) begin
        if (!req_we[cur]) begin
          m_rsp_own   = cur;
          m_rsp_addr  = req_addr[AW*cur +: AW];
          m_rsp_plane = req_plane[2*cur +: 2];
        end
        m_cnt++;
        if (req_last[cur] || m_cnt == MAXB) begin
          m_err = !req_last[cur];
          m_ptr = (cur + 1) % NREQ;
          m_own = -1;
          m_cnt = 0;
        end
        drv[cur].beat++;
        drv[cur].cur_we = pick_we(drv[cur].mode);
        if (drv[cur].beat == drv[cur].len) begin
          if (drv[cur].reps > 0) begin
            drv[cur].reps--;
            drv[cur].addr0 += drv[cur].len;
            drv[cur].beat = 0;
            drv[cur].gap_cnt = 0;
          end else begin
            drv[cur].act = 1'b0;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run_until_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((m_own >= 0 || any_active()) && n < max_cycles) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, n < max_cycles, 1'b1);
    step();
    step();
  endtask

  task automatic wait_owner(input string tag, input int who, input int max_cycles);
    int n;
    n = 0;
    while (m_own != who && n < max_cycles) begin
      step();
      n++;
    end
    check({tag, "_wait"}, n < max_cycles, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, exp_first;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_last = '0;
    req_plane = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      drv[i] = '{default: 0};
      drv[i].gap_at = -1;
    end
    model_reset();
    prev_busy = 1'b0; err_seen = 0; rsp_cnt1 = 0;

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_owner", owner, '0);
    check("rst_err", err_overrun, 1'b0);
    check("rst_fb_en", {fb_wr_en, fb_rd_en}, 2'b00);
    rst = 1'b0;
    step();

    // Single 4-beat read burst from req1, addr 10..13, plane U
    start_burst(1, 4, 3, 0, 10, 1, -1, 0, 0, 0);
    run_until_idle("rd_burst", 30);
    check("rd_burst_rsp_count", rsp_cnt1, 4);

    // All three continuously valid with 2-beat bursts: strict rotation
    starts.delete();
    for (int i = 0; i < NREQ; i++) start_burst(i, 2, 1, 2, 100 * i, i, -1, 0, 0, 3);
    run_until_idle("rotation", 100);
    check("rotation_grants", starts.size(), 12);
    for (int k = 0; k < 12 && k < starts.size(); k++)
      check($sformatf("rotation_grant%0d", k), starts[k], (2 + k) % 3);

    // Overrun: req2 sends 18 beats with last only on beat 18; req0 waits
    starts.delete();
    err_seen = 0;
    start_burst(2, 18, 17, 2, 500, 2, -1, 0, 0, 0);
    wait_owner("overrun", 2, 10);
    start_burst(0, 2, 1, 0, 700, 0, -1, 0, 0, 0);
    run_until_idle("overrun", 80);
    check("overrun_pulses", err_seen, 1);
    check("overrun_next_grant", (starts.size() > 1) ? starts[1] : -1, 0);

    // Owner drops valid for 5 cycles mid-burst; req0 request is ignored meanwhile
    start_burst(1, 6, 5, 1, 900, 0, 2, 5, 0, 0);
    wait_owner("gap", 1, 10);
    start_burst(0, 1, 0, 0, 950, 0, -1, 0, 0, 0);
    n = 0;
    while (drv[1].gap_cnt < 3 && n < 20) begin step(); n++; end
    check("gap_hold_owner", owner, 1);
    check("gap_no_write", fb_wr_en, 1'b0);
    run_until_idle("gap", 40);

    // Reset during beat 3 of a 6-beat read burst (rr_ptr left non-zero first)
    start_burst(0, 2, 1, 0, 20, 0, -1, 0, 0, 0);
    run_until_idle("pre_rst", 20);
    start_burst(2, 6, 5, 0, 300, 2, -1, 0, 0, 0);
    n = 0;
    while (!(m_own == 2 && drv[2].beat == 2) && n < 20) begin step(); n++; end
    check("midrst_reach", n < 20, 1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_ready", req_ready, '0);
    check("midrst_rsp_valid", rsp_valid, '0);
    check("midrst_rd_en", fb_rd_en, 1'b0);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk);
    step();
    for (int i = 0; i < NREQ; i++) drv[i].act = 1'b0;
    rst = 1'b0;
    step();

    // Fresh arbitration from rr_ptr=0: req0/req1 read, req2 write
`ifdef AV2_FBA_WRITE_PRIORITY_EN
    exp_first = 2;
`else
    exp_first = 0;
`endif
    start_burst(0, 2, 1, 0, 40, 0, -1, 0, 0, 0);
    start_burst(1, 2, 1, 0, 60, 1, -1, 0, 0, 0);
    start_burst(2, 2, 1, 1, 80, 2, -1, 0, 0, 0);
    step();
    check("first_grant", owner, exp_first);
    check("first_grant_busy", busy, 1'b1);
    run_until_idle("first_grant", 40);

    // Random bursts, lengths beyond MAX_BURST included, with valid drops
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!drv[i].act && $urandom_range(99) < 15) begin
          n = int'($urandom_range(20, 1));
          start_burst(i, n, n - 1, 2, int'($urandom_range(65535)), int'($urandom_range(2)),
                      int'($urandom_range(n - 1)), int'($urandom_range(3)), 20, 0);
        end
      end
      step();
    end
    run_until_idle("random", 400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
